multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle 16-bit RISC core. Takes decoded fields from the instruction
//  parser and status flags. Sequences FETCH/DECODE/EXEC/MEM/WB. Drives all datapath enables and
//  muxes, and the memory request/ready handshake. One instruction is in flight at a time.
// PARAMETERS
//  TIMEOUT_W  4  width of memory wait counter; Mem_Err after 2**TIMEOUT_W-1 cycles without Mem_Ready
// PORTS
//  Clk        in   1  system clock, rising edge
//  Reset      in   1  synchronous, active-high
//  Opcode     in   5  Instr[15:11]; valid from DECODE on (IR written at end of FETCH)
//  ALU_Op     in   2  Instr[1:0] for R-type ALU
//  Cond       in   3  Instr[10:8] branch condition
//  Flag_Z/N/C/V in 1 each  registered ALU flags
//  Mem_Ready  in   1  memory completes request this cycle
//  Mem_Read   out  1  read request;  Mem_Write out 1 write request
//  Addr_Sel   out  1  0=PC, 1=ALU result as memory address
//  IR_Write   out  1  latch instruction;  PC_Write out 1 update PC
//  PC_Src     out  2  00=PC+1, 01=PC+sext(imm8) (Bcc), 10=PC+sext(Label11) (JMP)
//  ALU_Src    out  1  0=Rn, 1=zext(imm5);  ALU_Ctrl out 2 ALU function
//  Flag_Write out  1  latch flags;  Reg_Write out 1 write Rd
//  WB_Sel     out  2  00=ALU, 01=memory data, 10={imm8,8'h00} (LHI)
//  Out_En     out  1  output port latches Rm (OutR);  Mem_Err out 1 one-cycle pulse on timeout
//  Illegal    out  1  one-cycle pulse in DECODE on an unknown opcode
// BEHAVIOUR
//  Opcodes: 00000 ALU-R, 00001 LHI, 00011 LDR, 00101 STR, 00111 ADDI, 10000 JMP, 11000 Bcc, 11100 OutR.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Outputs are Moore, decoded from state+Opcode.
//   Exceptions: FETCH/MEM completion strobes, and the Bcc PC_Write, which is also qualified by flags.
//  Reset: state<=FETCH, wait counter<=0. Every output is 0 while Reset is high.
//  FETCH: Mem_Read=1, Addr_Sel=0. On Mem_Ready: IR_Write=1, PC_Write=1, PC_Src=00 -> DECODE.
//   Otherwise stay in FETCH and count.
//  DECODE: no enables. Known opcode -> EXEC. Unknown opcode: Illegal=1 -> FETCH (executes as NOP).
//  EXEC by opcode:
//   ALU-R: ALU_Ctrl=ALU_Op, ALU_Src=0, Flag_Write=1 -> WB.
//   ADDI: ALU_Ctrl=00, ALU_Src=1, Flag_Write=1 -> WB.
//   LHI: no enables -> WB.
//   LDR/STR: ALU_Ctrl=00, ALU_Src=1, no flags -> MEM.
//   JMP: PC_Write=1, PC_Src=10 -> FETCH.
//   Bcc: PC_Src=01; PC_Write=1 only if cond true -> FETCH.
//   OutR: Out_En=1 -> FETCH.
//  Cond: 000 EQ(Z), 001 NE(!Z), 010 CS(C), 011 CC(!C), 100 MI(N), 101 PL(!N), 110 VS(V), 111 AL.
//  MEM: Addr_Sel=1; Mem_Read=1 (LDR) or Mem_Write=1 (STR). On Mem_Ready: LDR -> WB, STR -> FETCH.
//  WB: Reg_Write=1, one cycle -> FETCH. WB_Sel: 01 for LDR, 10 for LHI, 00 otherwise.
//  Latency with Mem_Ready=1: ALU-R/ADDI/LHI 4 cycles, LDR 5, STR 4, JMP/Bcc/OutR 3.
//  Each extra cycle of memory wait adds 1.
//  Wait counter: cleared on entry to FETCH/MEM and on Mem_Ready; +1 per wait cycle.
//   At all-ones: Mem_Err=1, request dropped, -> FETCH. No WB, no PC change; a FETCH timeout
//   re-fetches the same PC.
//  Mem_Ready outside FETCH/MEM is ignored. Mem_Read and Mem_Write are never both high.
//  Reset mid-instruction: aborts it next edge. No partial Reg_Write, PC_Write or Mem_Write
//  after Reset is seen.
// CONFIGURATION
//  SINGLE_STEP_EN defined: extra inputs Step_Mode and Step (1 bit each).
//   When Step_Mode=1, FETCH issues no Mem_Read until a Step pulse has been seen.
//   The Step pulse is latched in a 1-bit armed flag, cleared when IR_Write fires.
//   Step_Mode=0 gives free-running operation.
//  SINGLE_STEP_EN undefined: no such ports; always free-running, identical timing to above.
// TESTING
//  ADD R6,R5,R7 (00000_110_101_111_00), Mem_Ready=1:
//   states F,D,E,W; Flag_Write in E; Reg_Write/WB_Sel=00 in W; 4 cycles.
//  LDR R3,[R6,#24] with Mem_Ready delayed 2 cycles in MEM:
//   Addr_Sel=1 for 3 cycles, then WB_Sel=01 Reg_Write; 7 cycles total.
//  BCC (11000_011_...) with C=0: PC_Write=1 PC_Src=01.
//   Same with C=1: PC_Write stays 0. Both 3 cycles.
//  Mem_Ready held 0 in FETCH: Mem_Err pulses after 15 cycles.
//   No IR_Write/PC_Write; FETCH restarts.
//  Opcode 11111: Illegal pulse in DECODE, no enables, back to FETCH.
//   Reset asserted in MEM of STR: Mem_Write low next cycle, state FETCH.
//  SINGLE_STEP_EN, Step_Mode=1: no Mem_Read until Step.
//   One Step -> exactly one instruction retires, then hold.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: bundle between the multi-cycle core control FSM and its datapath/memory.
//   Decoded fields : opcode[4:0], alu_op[1:0], cond[2:0]
//   Status         : flag_z, flag_n, flag_c, flag_v, mem_ready
//   Single step    : step_mode, step (only when SINGLE_STEP_EN is defined)
//   Memory request : mem_read, mem_write, addr_sel
//   Datapath ctrl  : ir_write, pc_write, pc_src[1:0], alu_src, alu_ctrl[1:0], flag_write,
//                    reg_write, wb_sel[1:0], out_en
//   Status pulses  : mem_err, illegal
// Modports: master = control FSM, slave = datapath/memory side.
interface multi_cycle_ctrl_if;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned COND_W = 3;
    localparam int unsigned SEL_W  = 2;

    logic [OPC_W-1:0]  opcode;
    logic [SEL_W-1:0]  alu_op;
    logic [COND_W-1:0] cond;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              flag_v;
    logic              mem_ready;
`ifdef SINGLE_STEP_EN
    logic              step_mode;
    logic              step;
`endif
    logic              mem_read;
    logic              mem_write;
    logic              addr_sel;
    logic              ir_write;
    logic              pc_write;
    logic [SEL_W-1:0]  pc_src;
    logic              alu_src;
    logic [SEL_W-1:0]  alu_ctrl;
    logic              flag_write;
    logic              reg_write;
    logic [SEL_W-1:0]  wb_sel;
    logic              out_en;
    logic              mem_err;
    logic              illegal;

    modport master (
        input  opcode, alu_op, cond, flag_z, flag_n, flag_c, flag_v, mem_ready,
`ifdef SINGLE_STEP_EN
        input  step_mode, step,
`endif
        output mem_read, mem_write, addr_sel, ir_write, pc_write, pc_src, alu_src,
               alu_ctrl, flag_write, reg_write, wb_sel, out_en, mem_err, illegal
    );

    modport slave (
        output opcode, alu_op, cond, flag_z, flag_n, flag_c, flag_v, mem_ready,
`ifdef SINGLE_STEP_EN
        output step_mode, step,
`endif
        input  mem_read, mem_write, addr_sel, ir_write, pc_write, pc_src, alu_src,
               alu_ctrl, flag_write, reg_write, wb_sel, out_en, mem_err, illegal
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle 16-bit RISC core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for one instruction at a time and drives the datapath
// enables/muxes plus the memory request/ready handshake, with a memory wait timeout.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; forces every output low while high
//   bus   - multi_cycle_ctrl_if.master (decoded fields, flags, memory handshake, controls)
// Parameter TIMEOUT_W: wait counter width; mem_err after 2**TIMEOUT_W-1 cycles without mem_ready.
// Optional feature macro SINGLE_STEP_EN: adds step_mode/step; with step_mode=1 FETCH only
// requests memory after a step pulse has been latched.
// Controls are decoded from state+opcode (not registered) so strobes land in the cycle
// the handshake completes.
module multi_cycle_ctrl #(
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    multi_cycle_ctrl_if.master  bus
);
    localparam int unsigned ST_W = 3;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LHI  = 5'b00001;
    localparam logic [4:0] OP_LDR  = 5'b00011;
    localparam logic [4:0] OP_STR  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_BCC  = 5'b11000;
    localparam logic [4:0] OP_OUT  = 5'b11100;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 timeout;
    logic                 fetch_go;
    logic                 known_op;
    logic                 cond_true;
    logic                 waiting;

    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       flag_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       out_en;
    logic       mem_err;
    logic       illegal;

    assign timeout = &wait_cnt;

`ifdef SINGLE_STEP_EN
    // Latched step pulse; consumed when the stepped instruction is loaded.
    logic armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (ir_write) begin
            armed <= 1'b0;
        end else if (bus.step) begin
            armed <= 1'b1;
        end
    end

    assign fetch_go = !bus.step_mode || armed;
`else
    assign fetch_go = 1'b1;
`endif

    // Opcode legality
    always_comb begin
        known_op = 1'b0;
        case (bus.opcode)
            OP_ALU, OP_LHI, OP_LDR, OP_STR, OP_ADDI, OP_JMP, OP_BCC, OP_OUT: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    end

    // Branch condition evaluation against registered flags
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true =  bus.flag_z;
            3'b001:  cond_true = !bus.flag_z;
            3'b010:  cond_true =  bus.flag_c;
            3'b011:  cond_true = !bus.flag_c;
            3'b100:  cond_true =  bus.flag_n;
            3'b101:  cond_true = !bus.flag_n;
            3'b110:  cond_true =  bus.flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // A request is outstanding and unanswered this cycle
    assign waiting = ((state == S_FETCH && fetch_go) || state == S_MEM)
                     && !bus.mem_ready && !timeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter: idles at zero so each FETCH/MEM entry starts a fresh count
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (timeout) begin
                    state_nxt = S_FETCH;
                end else if (fetch_go && bus.mem_ready) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = known_op ? S_EXEC : S_FETCH;
            S_EXEC: begin
                case (bus.opcode)
                    OP_ALU, OP_ADDI, OP_LHI: state_nxt = S_WB;
                    OP_LDR, OP_STR:          state_nxt = S_MEM;
                    default:                 state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (timeout) begin
                    state_nxt = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_nxt = (bus.opcode == OP_LDR) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Output decode; everything held low during reset
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src    = 1'b0;
        alu_ctrl   = 2'b00;
        flag_write = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        out_en     = 1'b0;
        mem_err    = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    if (timeout) begin
                        mem_err = 1'b1;
                    end else if (fetch_go) begin
                        mem_read = 1'b1;
                        if (bus.mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                S_DECODE: illegal = !known_op;
                S_EXEC: begin
                    case (bus.opcode)
                        OP_ALU: begin
                            alu_ctrl   = bus.alu_op;
                            flag_write = 1'b1;
                        end
                        OP_ADDI: begin
                            alu_src    = 1'b1;
                            flag_write = 1'b1;
                        end
                        OP_LDR, OP_STR: alu_src = 1'b1;
                        OP_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                        end
                        OP_BCC: begin
                            pc_src   = 2'b01;
                            pc_write = cond_true;
                        end
                        OP_OUT:  out_en = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (timeout) begin
                        mem_err = 1'b1;
                    end else begin
                        addr_sel  = 1'b1;
                        mem_read  = (bus.opcode == OP_LDR);
                        mem_write = (bus.opcode == OP_STR);
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (bus.opcode == OP_LDR) begin
                        wb_sel = 2'b01;
                    end else if (bus.opcode == OP_LHI) begin
                        wb_sel = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.addr_sel   = addr_sel;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_src    = alu_src;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.flag_write = flag_write;
    assign bus.reg_write  = reg_write;
    assign bus.wb_sel     = wb_sel;
    assign bus.out_en     = out_en;
    assign bus.mem_err    = mem_err;
    assign bus.illegal    = illegal;
endmodule
